// File: rtl/farm_vehicle_detector.sv
// Farm-road loop sensor conditioning, vehicle queue count, service request FSM and wait timeout.
// Optional stuck-sensor detection is compiled in with FARM_SENSOR_FAULT_EN.
module farm_vehicle_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W         = 4,
    parameter int MAX_WAIT        = 20,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sensor_raw,
    input  logic               farm_green,
    output logic               farm_request,
    output logic [COUNT_W-1:0] vehicle_count,
    output logic               wait_timeout,
    output logic               sensor_fault
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_W = $clog2(MAX_WAIT + 1);
    localparam logic [DEB_W-1:0]   DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TMR_MAX  = TMR_W'(MAX_WAIT);
    localparam logic [TMR_W-1:0]   TMR_FIRE = TMR_W'(MAX_WAIT - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_GRANTED
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sync1;
    logic               r_sync_q;
    logic               r_deb;
    logic               r_deb_d;
    logic [DEB_W-1:0]   r_deb_cnt;
    logic [COUNT_W-1:0] r_count;
    logic [TMR_W-1:0]   r_wait_timer;
    logic               w_arrival;
    logic               w_departure;
    logic               w_fsm_request;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync_q  <= 1'b0;
            r_deb     <= 1'b0;
            r_deb_d   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1  <= sensor_raw;
            r_sync_q <= r_sync1;
            r_deb_d  <= r_deb;
            if (r_sync_q == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_deb     <= r_sync_q;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    // Edges of the debounced level; they cannot coincide since r_deb changes at most once per edge.
    assign w_arrival   = r_deb & ~r_deb_d;
    assign w_departure = ~r_deb & r_deb_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_arrival) begin
            if (r_count != CNT_MAX) r_count <= r_count + 1'b1;
        end else if (w_departure && farm_green) begin
            if (r_count != '0) r_count <= r_count - 1'b1;
        end
    end

    // Held at zero outside PENDING, so every entry into PENDING starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_timer <= '0;
        end else if (r_state != S_PENDING) begin
            r_wait_timer <= '0;
        end else if (r_wait_timer != TMR_MAX) begin
            r_wait_timer <= r_wait_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (farm_green)     w_state_nxt = S_GRANTED;
                else if (w_arrival) w_state_nxt = S_PENDING;
            end
            S_PENDING: begin
                if (farm_green) w_state_nxt = S_GRANTED;
            end
            S_GRANTED: begin
                if (!farm_green) w_state_nxt = (r_count != '0) ? S_PENDING : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_fsm_request = (r_state == S_PENDING);
    assign wait_timeout  = (r_state == S_PENDING) && (r_wait_timer == TMR_FIRE);
    assign vehicle_count = r_count;

`ifdef FARM_SENSOR_FAULT_EN
    localparam int STK_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STUCK_CYCLES);
    localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_CYCLES - 1);

    logic [STK_W-1:0] r_stuck_cnt;
    logic             r_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stuck_cnt <= '0;
            r_fault     <= 1'b0;
        end else begin
            if (!r_deb)                       r_stuck_cnt <= '0;
            else if (r_stuck_cnt != STK_MAX)  r_stuck_cnt <= r_stuck_cnt + 1'b1;
            if (r_deb && r_stuck_cnt == STK_LAST) r_fault <= 1'b1;
        end
    end

    // A stuck loop forces the farm road to keep being served.
    assign sensor_fault = r_fault;
    assign farm_request = w_fsm_request | r_fault;
`else
    logic w_unused_stuck;
    assign w_unused_stuck = (STUCK_CYCLES > 0);
    assign sensor_fault   = 1'b0;
    assign farm_request   = w_fsm_request;
`endif

endmodule

// File: tb/tb_farm_vehicle_detector.sv
// Directed bench for farm_vehicle_detector: reset, debounce latency, queue service, saturation,
// timeout and stuck-sensor behaviour (expectations follow FARM_SENSOR_FAULT_EN).
module tb_farm_vehicle_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_raw;
    logic       farm_green;
    logic       farm_request;
    logic [3:0] vehicle_count;
    logic       wait_timeout;
    logic       sensor_fault;
    logic       req_s;
    logic [1:0] cnt_s;
    logic       to_s;
    logic       fault_s;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FARM_SENSOR_FAULT_EN
    localparam logic FAULT_EN = 1'b1;
`else
    localparam logic FAULT_EN = 1'b0;
`endif

    farm_vehicle_detector u_dut (
        .clk          (clk),
        .reset        (reset),
        .sensor_raw   (sensor_raw),
        .farm_green   (farm_green),
        .farm_request (farm_request),
        .vehicle_count(vehicle_count),
        .wait_timeout (wait_timeout),
        .sensor_fault (sensor_fault)
    );

    farm_vehicle_detector #(.COUNT_W(2)) u_sat (
        .clk          (clk),
        .reset        (reset),
        .sensor_raw   (sensor_raw),
        .farm_green   (farm_green),
        .farm_request (req_s),
        .vehicle_count(cnt_s),
        .wait_timeout (to_s),
        .sensor_fault (fault_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        sensor_raw = 1'b0;
        farm_green = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic vehicle_pulse();
        sensor_raw = 1'b1;
        repeat (8) tick();
        sensor_raw = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        int n_pulse;
        int pulse_at;

        do_reset();
        chk("rst_req", farm_request, 0);
        chk("rst_cnt", vehicle_count, 0);
        chk("rst_to", wait_timeout, 0);
        chk("rst_fault", sensor_fault, 0);

        // three-cycle glitch must be rejected
        sensor_raw = 1'b1;
        repeat (3) tick();
        sensor_raw = 1'b0;
        repeat (12) tick();
        chk("glitch_req", farm_request, 0);
        chk("glitch_cnt", vehicle_count, 0);

        // arrival latency: request appears after the 7th edge counted from the first sampling edge (k+6)
        sensor_raw = 1'b1;
        repeat (6) tick();
        chk("lat_req_early", farm_request, 0);
        tick();
        chk("lat_req", farm_request, 1);
        chk("lat_cnt", vehicle_count, 1);

        // timeout: cycle 1 of PENDING is now; departure without green is ignored
        sensor_raw = 1'b0;
        n_pulse    = 0;
        pulse_at   = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) tick();
            if (wait_timeout) begin
                n_pulse++;
                pulse_at = c;
            end
        end
        chk("to_pulses", n_pulse, 1);
        chk("to_cycle", pulse_at, 20);
        chk("to_cnt_keep", vehicle_count, 1);
        chk("to_req_keep", farm_request, 1);

        // queue service with a vehicle sitting on the loop when green arrives
        vehicle_pulse();
        sensor_raw = 1'b1;
        repeat (8) tick();
        chk("q_cnt3", vehicle_count, 3);
        farm_green = 1'b1;
        tick();
        chk("q_green_req", farm_request, 0);
        sensor_raw = 1'b0;
        repeat (8) tick();
        chk("q_depart", vehicle_count, 2);
        vehicle_pulse();
        chk("q_green_arr_dep", vehicle_count, 2);
        chk("q_green_req2", farm_request, 0);
        farm_green = 1'b0;
        tick();
        chk("q_repend_req", farm_request, 1);
        chk("q_repend_cnt", vehicle_count, 2);

        // saturation: 5 arrivals, 4-bit counter vs 2-bit counter
        do_reset();
        repeat (5) vehicle_pulse();
        chk("sat_cnt4", vehicle_count, 5);
        chk("sat_cnt2", cnt_s, 3);

        // last vehicle served -> IDLE
        do_reset();
        sensor_raw = 1'b1;
        repeat (8) tick();
        chk("idle_cnt1", vehicle_count, 1);
        farm_green = 1'b1;
        tick();
        sensor_raw = 1'b0;
        repeat (8) tick();
        chk("idle_cnt0", vehicle_count, 0);
        farm_green = 1'b0;
        tick();
        chk("idle_req", farm_request, 0);
        n_pulse = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (wait_timeout) n_pulse++;
        end
        chk("idle_no_to", n_pulse, 0);
        vehicle_pulse();
        chk("idle_rearm_req", farm_request, 1);
        chk("idle_rearm_cnt", vehicle_count, 1);

        // stuck sensor
        do_reset();
        sensor_raw = 1'b1;
        repeat (60) tick();
        chk("stuck_early", sensor_fault, 0);
        repeat (20) tick();
        chk("stuck_fault", sensor_fault, FAULT_EN);
        farm_green = 1'b1;
        repeat (3) tick();
        chk("stuck_fault_green", sensor_fault, FAULT_EN);
        chk("stuck_req_green", farm_request, FAULT_EN);
        farm_green = 1'b0;

        // asynchronous reset in PENDING with three queued vehicles
        do_reset();
        repeat (3) vehicle_pulse();
        chk("ar_cnt3", vehicle_count, 3);
        chk("ar_req1", farm_request, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("ar_req", farm_request, 0);
        chk("ar_cnt", vehicle_count, 0);
        chk("ar_to", wait_timeout, 0);
        chk("ar_fault", sensor_fault, 0);
        tick();
        reset = 1'b0;
        n_pulse = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (wait_timeout || farm_request) n_pulse++;
        end
        chk("ar_idle", n_pulse, 0);
        chk("ar_idle_cnt", vehicle_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/farm_vehicle_detector.md
# farm_vehicle_detector

Upstream companion to the highway/farm traffic light controller. Conditions the raw farm-road stop-line loop sensor and produces the farm service request that the controller consumes. Also tracks the number of queued farm vehicles and flags excessive waits. With the fault feature compiled in, it also flags a stuck sensor. It observes the controller's `farm_green` lamp output to know when a request has been served.

## Interface

**Parameters**

- `DEBOUNCE_CYCLES`, default 4: consecutive mismatching samples required to change the debounced level; must be ≥1.
- `COUNT_W`, default 4: width of the queue counter.
- `MAX_WAIT`, default 20: cycles in PENDING before `wait_timeout` fires; must be ≥1.
- `STUCK_CYCLES`, default 64: continuous debounced-high cycles that declare a sensor fault.

**Ports** (clock and reset first)

- `clk` input 1: the single clock; everything is on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `sensor_raw` input 1: asynchronous loop-detector level; 1 means a vehicle is present.
- `farm_green` input 1: grant from the controller; 1 while the farm road is green.
- `farm_request` output 1: the farm road needs service.
- `vehicle_count` output COUNT_W: number of queued farm vehicles.
- `wait_timeout` output 1: one-cycle pulse on excessive wait.
- `sensor_fault` output 1: sticky stuck-sensor flag.

## Operation

**Input conditioning**

- `sensor_raw` passes through a 2-flop synchronizer to give `sync_q`.
- Debounce counter:
  - Increments on every edge where `sync_q` ≠ `deb`.
  - Clears to 0 on any edge where they match.
  - When it reaches DEBOUNCE_CYCLES−1 with a mismatch still present, `deb` takes `sync_q` and the counter clears.
- Arrival = rising edge of `deb`. Departure = falling edge of `deb`. The two never coincide.

**Queue counter**

- Arrival increments `vehicle_count`, saturating at 2^COUNT_W−1.
- Departure decrements it only while `farm_green`=1, saturating at 0.
- Departures while `farm_green`=0 are ignored.

**FSM** (states IDLE, PENDING, GRANTED)

- IDLE:
  - `farm_request`=0.
  - Arrival → PENDING.
  - `farm_green`=1 → GRANTED.
- PENDING:
  - `farm_request`=1.
  - `wait_timer` increments each cycle and saturates at MAX_WAIT.
  - `wait_timeout` pulses for exactly one cycle when `wait_timer` reaches MAX_WAIT−1. This happens once per PENDING episode.
  - `farm_green`=1 → GRANTED.
- GRANTED:
  - `farm_request`=0.
  - Arrivals still count.
  - On `farm_green`=0: go to PENDING (`wait_timer` cleared) if `vehicle_count`>0, otherwise IDLE.

**Timer width:** `wait_timer` is $clog2(MAX_WAIT+1) bits, cleared on every entry to PENDING.

## Timing

- Reset values: `farm_request`=0, `vehicle_count`=0, `wait_timeout`=0, `sensor_fault`=0. Internal state also resets: state IDLE, `deb`=0, synchronizer flops 0, all counters 0.
- Reset asserted mid-operation: immediate return to the above values; a sticky fault is cleared too.
- Latency from `sensor_raw` rising (stable from before edge k) to outputs:
  - `deb`=1 after edge k+1+DEBOUNCE_CYCLES.
  - `farm_request`=1 and `vehicle_count` updated after edge k+2+DEBOUNCE_CYCLES.
  - With defaults this is 6 cycles after edge k.
- Glitches are rejected: a `sync_q` pulse shorter than DEBOUNCE_CYCLES cycles never changes `deb`.
- `farm_green` is sampled directly; the controller is synchronous to `clk`.
- A grant and an arrival on the same edge: FSM goes to GRANTED and the count still increments.
- `wait_timeout` never fires outside PENDING. A grant on the same edge as timer expiry still produces the pulse.

## Configuration

- **With `FARM_SENSOR_FAULT_EN` defined:**
  - A stuck counter increments while `deb`=1 and clears when `deb`=0.
  - On reaching STUCK_CYCLES, `sensor_fault` sets to 1 and stays set until `reset`.
  - While `sensor_fault`=1, `farm_request` is forced to 1 (fail-safe farm service). The FSM and counter keep running unchanged.
- **Without the macro:** `sensor_fault` is tied to 0, no stuck counter is built, and `farm_request` comes from the FSM only.

## Test plan

- **Reset:** assert `reset` asynchronously mid-cycle while in PENDING with `vehicle_count`=3 → all outputs read 0 immediately; after release the block is in IDLE.
- **Arrival latency:** defaults; `sensor_raw` held at 1 → `farm_request`=1 and `vehicle_count`=1 exactly 6 cycles after the first sampling edge. A 3-cycle `sensor_raw` pulse → no change.
- **Queue service:** 3 arrivals, then `farm_green`=1 with 2 departures, then `farm_green`=0 → `vehicle_count` goes 3→1, `farm_request` drops during green and reasserts the cycle after green falls (PENDING). Alternate case: 3 departures → count 0 and return to IDLE.
- **Saturation:** COUNT_W=2 with 5 arrivals → count holds at 3. Departures at count 0 → count stays 0.
- **Timeout:** MAX_WAIT=20, no grant → exactly one `wait_timeout` pulse, on the 20th cycle after entering PENDING; none afterwards.
- **Stuck sensor:** with `FARM_SENSOR_FAULT_EN` and STUCK_CYCLES=64, `sensor_raw` held at 1 → `sensor_fault`=1 after 64 debounced-high cycles and stays 1 through grants. `farm_request`=1 even in GRANTED. Without the macro → `sensor_fault` stays 0.
